// File: rtl/montgomery_sched.sv
// Round-robin front end for a shared, fixed-latency Montgomery reduction datapath.
// Owns the modulus configuration and tags every issued operation with its requester ID
// so results can be steered back once the datapath returns them.
module montgomery_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LAT     = 12,
    parameter int unsigned W       = 64,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*W-1:0] req_x_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 cfg_valid_i,
    input  logic [W-1:0]         cfg_m_i,
    input  logic [W-1:0]         cfg_minv_i,
    input  logic [6:0]           cfg_k_i,
    output logic                 cfg_ready_o,
    output logic                 red_start_o,
    output logic [W-1:0]         red_x_o,
    output logic [W-1:0]         red_m_o,
    output logic [W-1:0]         red_minv_o,
    output logic [6:0]           red_k_o,
    input  logic                 red_valid_i,
    input  logic [W-1:0]         red_result_i,
    output logic                 rsp_valid_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [W-1:0]         rsp_data_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int unsigned CntW = $clog2(LAT + 2);

    typedef enum logic [1:0] {StUnconf, StRun, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [IDW-1:0]            red_id_q;
    logic [LAT-1:0]            tag_v_q;
    logic [LAT-1:0][IDW-1:0]   tag_id_q;

    logic                      gnt_found;
    logic [IDW-1:0]            gnt_id;
    logic [W-1:0]              gnt_x;
    logic                      grant_en;
    logic                      accept;
    logic                      cfg_legal;
    logic                      cfg_load;
    logic                      cfg_bad;

    // Modulus must be odd for Montgomery reduction; k is limited to the datapath width.
    assign cfg_legal = cfg_m_i[0] && (cfg_k_i != 7'd0) && (32'(cfg_k_i) <= W);
    assign accept    = |(req_valid_i & req_ready_o);
    assign busy_o    = (cnt_q != '0);

    // Round-robin search: first valid requester at or after ptr_q.
    always_comb begin
        logic [IDW-1:0] idx;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IDW'((32'(ptr_q) + off) % NUM_REQ);
            if (!gnt_found && req_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
        gnt_x = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == gnt_id) gnt_x = req_x_i[i*W +: W];
        end
    end

    // Control FSM: config handshake, grant enable and next state.
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        grant_en    = 1'b0;
        cfg_load    = 1'b0;
        cfg_bad     = 1'b0;
        case (state_q)
            StUnconf: begin
                cfg_ready_o = cfg_valid_i;
                if (cfg_valid_i) begin
                    if (cfg_legal) begin
                        cfg_load = 1'b1;
                        state_d  = StRun;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            StRun: begin
                if (cfg_valid_i) state_d = StDrain;
                else             grant_en = 1'b1;
            end
            StDrain: begin
                if (!cfg_valid_i) begin
                    state_d = StRun;
                end else if (cnt_q == '0) begin
                    // Pipeline empty: safe to swap the modulus.
                    cfg_ready_o = 1'b1;
                    if (cfg_legal) begin
                        cfg_load = 1'b1;
                        state_d  = StRun;
                    end else begin
                        cfg_bad = 1'b1;
                        state_d = StUnconf;
                    end
                end
            end
            default: state_d = StUnconf;
        endcase
        req_ready_o = '0;
        if (grant_en && gnt_found) req_ready_o[gnt_id] = 1'b1;
    end

    // Pointer advance and in-flight bookkeeping.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        cnt_d = cnt_q;
        if (accept && !red_valid_i)                      cnt_d = cnt_q + 1'b1;
        else if (!accept && red_valid_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    end

    // State, issue, config, tag pipeline and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StUnconf;
            ptr_q       <= '0;
            cnt_q       <= '0;
            red_start_o <= 1'b0;
            red_x_o     <= '0;
            red_id_q    <= '0;
            red_m_o     <= '0;
            red_minv_o  <= '0;
            red_k_o     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            red_start_o <= accept;
            if (accept) begin
                red_x_o  <= gnt_x;
                red_id_q <= gnt_id;
            end
            if (cfg_load) begin
                red_m_o    <= cfg_m_i;
                red_minv_o <= cfg_minv_i;
                red_k_o    <= cfg_k_i;
            end
            // Stage 0 captures the issue cycle so the head lines up with red_valid_i.
            tag_v_q  <= {tag_v_q[LAT-2:0], red_start_o};
            tag_id_q <= {tag_id_q[LAT-2:0], red_id_q};
            rsp_valid_o <= red_valid_i;
            if (red_valid_i) begin
                rsp_id_o   <= tag_id_q[LAT-1];
                rsp_data_o <= red_result_i;
            end
            if (cfg_bad || (red_valid_i != tag_v_q[LAT-1])) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_montgomery_sched.sv
// Directed bench for montgomery_sched with a behavioural LAT-cycle REDC datapath.
`timescale 1ns/1ps
module tb_montgomery_sched;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LAT     = 12;
    localparam int unsigned W       = 64;
    localparam int unsigned IDW     = 2;
    localparam int unsigned DW      = 2 * W + 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b1;
    logic [NUM_REQ-1:0]   req_valid_i = '0;
    logic [NUM_REQ*W-1:0] req_x_i = '0;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic                 cfg_valid_i = 1'b0;
    logic [W-1:0]         cfg_m_i = '0;
    logic [W-1:0]         cfg_minv_i = '0;
    logic [6:0]           cfg_k_i = '0;
    logic                 cfg_ready_o;
    logic                 red_start_o;
    logic [W-1:0]         red_x_o;
    logic [W-1:0]         red_m_o;
    logic [W-1:0]         red_minv_o;
    logic [6:0]           red_k_o;
    logic                 red_valid_i;
    logic [W-1:0]         red_result_i;
    logic                 rsp_valid_o;
    logic [IDW-1:0]       rsp_id_o;
    logic [W-1:0]         rsp_data_o;
    logic                 busy_o;
    logic                 err_o;

    logic                 early = 1'b0;
    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   lat;
    int                   cnt;
    logic [W-1:0]         exp_data [4];

    montgomery_sched #(
        .NUM_REQ (NUM_REQ),
        .LAT     (LAT),
        .W       (W),
        .IDW     (IDW)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_x_i      (req_x_i),
        .req_ready_o  (req_ready_o),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_m_i      (cfg_m_i),
        .cfg_minv_i   (cfg_minv_i),
        .cfg_k_i      (cfg_k_i),
        .cfg_ready_o  (cfg_ready_o),
        .red_start_o  (red_start_o),
        .red_x_o      (red_x_o),
        .red_m_o      (red_m_o),
        .red_minv_o   (red_minv_o),
        .red_k_o      (red_k_o),
        .red_valid_i  (red_valid_i),
        .red_result_i (red_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] redc(input logic [W-1:0] x, input logic [W-1:0] m,
                                          input logic [W-1:0] minv, input logic [6:0] k);
        logic [DW-1:0] mask, u, t;
        mask = (DW'(1) << k) - DW'(1);
        u    = (DW'(x) * DW'(minv)) & mask;
        t    = (DW'(x) + u * DW'(m)) >> k;
        if (t >= DW'(m)) t = t - DW'(m);
        return t[W-1:0];
    endfunction

    // Datapath model: LAT-stage pipeline; 'early' taps one stage short.
    logic [LAT-1:0] dp_v_q;
    logic [W-1:0]   dp_r_q [LAT];
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dp_v_q <= '0;
            for (int i = 0; i < LAT; i++) dp_r_q[i] <= '0;
        end else begin
            dp_v_q    <= {dp_v_q[LAT-2:0], red_start_o};
            dp_r_q[0] <= redc(red_x_o, red_m_o, red_minv_o, red_k_o);
            for (int i = 1; i < LAT; i++) dp_r_q[i] <= dp_r_q[i-1];
        end
    end
    assign red_valid_i  = early ? dp_v_q[LAT-2] : dp_v_q[LAT-1];
    assign red_result_i = early ? dp_r_q[LAT-2] : dp_r_q[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Returns edges from the accept edge to the edge sampling rsp_valid_o, or -1.
    task automatic wait_rsp(input int budget, output int l);
        l = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (rsp_valid_o) begin
                l = k + 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        cfg_valid_i = 1'b0;
        early       = 1'b0;
        #2;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic configure(input logic [W-1:0] m, input logic [W-1:0] minv,
                             input logic [6:0] k);
        cfg_valid_i = 1'b1;
        cfg_m_i     = m;
        cfg_minv_i  = minv;
        cfg_k_i     = k;
        #1;
        check_eq("cfg_ready_unconf", 64'(cfg_ready_o), 64'd1);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        exp_data[0] = 64'd11;  // REDC(20) mod 13, k=4
        exp_data[1] = 64'd9;   // REDC(1)
        exp_data[2] = 64'd5;   // REDC(2)
        exp_data[3] = 64'd1;   // REDC(3)

        // Reset values
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_red_start", 64'(red_start_o), 64'd0);
        check_eq("rst_red_x", red_x_o, 64'd0);
        check_eq("rst_red_m", red_m_o, 64'd0);
        check_eq("rst_red_k", 64'(red_k_o), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("rst_rsp_data", rsp_data_o, 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready_o), 64'd0);
        check_eq("rst_cfg_ready", 64'(cfg_ready_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic reduction
        configure(64'd13, 64'd11, 7'd4);
        check_eq("cfg_m_loaded", red_m_o, 64'd13);
        check_eq("cfg_k_loaded", 64'(red_k_o), 64'd4);
        req_x_i[0 +: W] = 64'd20;
        req_valid_i = 4'b0001;
        #1;
        check_eq("basic_grant", 64'(req_ready_o), 64'b0001);
        tick();
        req_valid_i = '0;
        check_eq("basic_start", 64'(red_start_o), 64'd1);
        check_eq("basic_red_x", red_x_o, 64'd20);
        wait_rsp(40, lat);
        check_eq("basic_latency", 64'(lat), 64'd14);
        check_eq("basic_id", 64'(rsp_id_o), 64'd0);
        check_eq("basic_data", rsp_data_o, 64'd11);

        // Single op from requester 3 brings the pointer back to 0
        req_x_i[3*W +: W] = 64'd3;
        req_valid_i = 4'b1000;
        #1;
        check_eq("rr_pre_grant", 64'(req_ready_o), 64'b1000);
        tick();
        req_valid_i = '0;
        wait_rsp(40, lat);
        check_eq("rr_pre_id", 64'(rsp_id_o), 64'd3);
        check_eq("rr_pre_data", rsp_data_o, 64'd1);

        // Round-robin fairness
        req_x_i[0*W +: W] = 64'd20;
        req_x_i[1*W +: W] = 64'd1;
        req_x_i[2*W +: W] = 64'd2;
        req_x_i[3*W +: W] = 64'd3;
        req_valid_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", c), 64'(req_ready_o), 64'(4'b0001 << (c % 4)));
            tick();
        end
        req_valid_i = '0;
        wait_rsp(40, lat);
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("rr_rsp_valid%0d", c), 64'(rsp_valid_o), 64'd1);
            check_eq($sformatf("rr_rsp_id%0d", c), 64'(rsp_id_o), 64'(c % 4));
            check_eq($sformatf("rr_rsp_data%0d", c), rsp_data_o, exp_data[c % 4]);
            tick();
        end
        check_eq("rr_train_end", 64'(rsp_valid_o), 64'd0);

        // Config during traffic: 5 ops in flight, then a new modulus
        req_x_i[0 +: W] = 64'd20;
        req_valid_i = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        check_eq("drain_busy", 64'(busy_o), 64'd1);
        cfg_valid_i = 1'b1;
        cfg_m_i     = 64'd11;
        cfg_minv_i  = 64'd13;
        cfg_k_i     = 7'd4;
        #1;
        check_eq("drain_no_grant", 64'(req_ready_o), 64'd0);
        check_eq("drain_cfg_wait", 64'(cfg_ready_o), 64'd0);
        lat = -1;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (req_ready_o != '0) cnt++;
            if (cfg_ready_o) begin
                lat = k;
                break;
            end
        end
        check_eq("drain_cfg_delay", 64'(lat), 64'(LAT + 1));
        check_eq("drain_grants_seen", 64'(cnt), 64'd0);
        check_eq("drain_idle_at_cfg", 64'(busy_o), 64'd0);
        check_eq("drain_old_m", red_m_o, 64'd13);
        tick();
        cfg_valid_i = 1'b0;
        check_eq("drain_new_m", red_m_o, 64'd11);
        check_eq("drain_new_minv", red_minv_o, 64'd13);
        #1;
        check_eq("drain_resume_grant", 64'(req_ready_o), 64'b0001);
        tick();
        req_valid_i = '0;
        wait_rsp(40, lat);
        check_eq("newm_latency", 64'(lat), 64'd14);
        check_eq("newm_data", rsp_data_o, 64'd4);   // 20 * 16^-1 mod 11
        check_eq("newm_err", 64'(err_o), 64'd0);

        // Illegal config: even modulus
        do_reset();
        configure(64'd12, 64'd11, 7'd4);
        check_eq("illegal_err", 64'(err_o), 64'd1);
        check_eq("illegal_m_unloaded", red_m_o, 64'd0);
        req_valid_i = 4'b1111;
        #1;
        check_eq("illegal_no_grant", 64'(req_ready_o), 64'd0);
        tick();
        req_valid_i = '0;

        // Tag mismatch: datapath fires one cycle early
        do_reset();
        configure(64'd13, 64'd11, 7'd4);
        check_eq("tag_err_before", 64'(err_o), 64'd0);
        early = 1'b1;
        req_x_i[0 +: W] = 64'd20;
        req_valid_i = 4'b0001;
        tick();
        req_valid_i = '0;
        wait_rsp(40, lat);
        check_eq("tag_early_latency", 64'(lat), 64'd13);
        check_eq("tag_err_set", 64'(err_o), 64'd1);
        early = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check_eq("tag_err_sticky", 64'(err_o), 64'd1);

        // Reset mid-flight
        do_reset();
        configure(64'd13, 64'd11, 7'd4);
        req_valid_i = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        req_valid_i = '0;
        for (int c = 0; c < 3; c++) tick();
        check_eq("mid_busy", 64'(busy_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(busy_o), 64'd0);
        check_eq("mid_rst_m", red_m_o, 64'd0);
        check_eq("mid_rst_x", red_x_o, 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_eq("mid_rst_err", 64'(err_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (rsp_valid_o) cnt++;
        end
        check_eq("mid_no_rsp", 64'(cnt), 64'd0);
        req_valid_i = 4'b1111;
        #1;
        check_eq("mid_needs_cfg", 64'(req_ready_o), 64'd0);
        tick();
        req_valid_i = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
